// File: rtl/mrna_iso_seq.sv
// mRNA isolation sequencer: timed valve/pump program CELLS..COLLECT with abort.
// All outputs are registered from the next-state decode, so they track the state register with no lag.
module mrna_iso_seq #(
    parameter int TW         = 16,
    parameter int LOAD_T     = 100,
    parameter int LYSE_T     = 200,
    parameter int PUMP_T     = 10,
    parameter int MIX_ROUNDS = 8,
    parameter int SEP_T      = 50,
    parameter int WASTE_T    = 50,
    parameter int COLLECT_T  = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       cells_in_ctrl,
    output logic       cells_out_ctrl,
    output logic       beads_ctrl,
    output logic       lysis_in_ctrl,
    output logic       lysis_out_ctrl,
    output logic       sep_ctrl,
    output logic       sieve_ctrl,
    output logic       waste_ctrl,
    output logic       push_ctrl,
    output logic       collect_ctrl,
    output logic       pump1,
    output logic       pump2,
    output logic       pump3,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CELLS   = 4'd1,
        BEADS   = 4'd2,
        LYSE    = 4'd3,
        MIX     = 4'd4,
        SEP     = 4'd5,
        WASTE   = 4'd6,
        COLLECT = 4'd7,
        DONE    = 4'd8
    } state_t;

    typedef struct packed {
        logic cells_in;
        logic cells_out;
        logic beads;
        logic lysis_in;
        logic lysis_out;
        logic sep;
        logic sieve;
        logic waste;
        logic push;
        logic collect;
        logic p1;
        logic p2;
        logic p3;
        logic busy;
        logic done;
        logic aborted;
    } outs_t;

    localparam int RW = (MIX_ROUNDS > 1) ? $clog2(MIX_ROUNDS) : 1;
    localparam logic [RW-1:0] LAST_ROUND = RW'(MIX_ROUNDS - 1);

    function automatic logic [TW-1:0] dur(input int d);
        return TW'(d - 1);
    endfunction

    state_t        st_q, st_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    ph_q, ph_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic          abt_d;
    logic          tmr_zero;
    logic          is_busy;
    outs_t         out_q, out_d;

    assign tmr_zero = (tmr_q == '0);
    assign is_busy  = !(st_q inside {IDLE, DONE});

    always_comb begin
        st_d  = st_q;
        tmr_d = tmr_q;
        ph_d  = ph_q;
        rnd_d = rnd_q;
        abt_d = 1'b0;
        if (abort) begin
            st_d  = IDLE;
            tmr_d = '0;
            ph_d  = '0;
            rnd_d = '0;
            abt_d = is_busy;
        end else begin
            if (is_busy && !tmr_zero)
                tmr_d = tmr_q - TW'(1);
            case (st_q)
                IDLE, DONE: if (start) begin
                    st_d  = CELLS;
                    tmr_d = dur(LOAD_T);
                end
                CELLS: if (tmr_zero) begin
                    st_d  = BEADS;
                    tmr_d = dur(LOAD_T);
                end
                BEADS: if (tmr_zero) begin
                    st_d  = LYSE;
                    tmr_d = dur(LYSE_T);
                end
                LYSE: if (tmr_zero) begin
                    st_d  = MIX;
                    tmr_d = dur(PUMP_T);
                    ph_d  = '0;
                    rnd_d = '0;
                end
                // Timer counts one pump phase; phase/round counters span the whole MIX.
                MIX: if (tmr_zero) begin
                    tmr_d = dur(PUMP_T);
                    if (ph_q == 2'd2) begin
                        ph_d = '0;
                        if (rnd_q == LAST_ROUND) begin
                            st_d  = SEP;
                            tmr_d = dur(SEP_T);
                            rnd_d = '0;
                        end else begin
                            rnd_d = rnd_q + RW'(1);
                        end
                    end else begin
                        ph_d = ph_q + 2'd1;
                    end
                end
                SEP: if (tmr_zero) begin
                    st_d  = WASTE;
                    tmr_d = dur(WASTE_T);
                end
                WASTE: if (tmr_zero) begin
                    st_d  = COLLECT;
                    tmr_d = dur(COLLECT_T);
                end
                COLLECT: if (tmr_zero) begin
                    st_d  = DONE;
                    tmr_d = '0;
                end
                default: begin
                    st_d  = IDLE;
                    tmr_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        out_d         = '0;
        out_d.aborted = abt_d;
        out_d.busy    = !(st_d inside {IDLE, DONE});
        out_d.done    = (st_d == DONE);
        case (st_d)
            CELLS:   begin out_d.cells_in = 1'b1; out_d.cells_out = 1'b1; end
            BEADS:   out_d.beads = 1'b1;
            LYSE:    begin out_d.lysis_in = 1'b1; out_d.lysis_out = 1'b1; end
            MIX: begin
                out_d.sieve = 1'b1;
                out_d.p1    = (ph_d == 2'd0);
                out_d.p2    = (ph_d == 2'd1);
                out_d.p3    = (ph_d == 2'd2);
            end
            SEP:     begin out_d.sep = 1'b1; out_d.sieve = 1'b1; end
            WASTE:   begin out_d.waste = 1'b1; out_d.push = 1'b1; out_d.sieve = 1'b1; end
            COLLECT: begin out_d.collect = 1'b1; out_d.push = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q  <= IDLE;
            tmr_q <= '0;
            ph_q  <= '0;
            rnd_q <= '0;
            out_q <= '0;
        end else begin
            st_q  <= st_d;
            tmr_q <= tmr_d;
            ph_q  <= ph_d;
            rnd_q <= rnd_d;
            out_q <= out_d;
        end
    end

    assign state          = st_q;
    assign cells_in_ctrl  = out_q.cells_in;
    assign cells_out_ctrl = out_q.cells_out;
    assign beads_ctrl     = out_q.beads;
    assign lysis_in_ctrl  = out_q.lysis_in;
    assign lysis_out_ctrl = out_q.lysis_out;
    assign sep_ctrl       = out_q.sep;
    assign sieve_ctrl     = out_q.sieve;
    assign waste_ctrl     = out_q.waste;
    assign push_ctrl      = out_q.push;
    assign collect_ctrl   = out_q.collect;
    assign pump1          = out_q.p1;
    assign pump2          = out_q.p2;
    assign pump3          = out_q.p3;
    assign busy           = out_q.busy;
    assign done           = out_q.done;
    assign aborted        = out_q.aborted;

endmodule

// File: tb/tb_mrna_iso_seq.sv
// Directed bench for mrna_iso_seq: full run, pump pattern, abort, reset and start-while-busy.
module tb_mrna_iso_seq;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    logic cells_in_ctrl, cells_out_ctrl, beads_ctrl, lysis_in_ctrl, lysis_out_ctrl;
    logic sep_ctrl, sieve_ctrl, waste_ctrl, push_ctrl, collect_ctrl;
    logic pump1, pump2, pump3, busy, done, aborted;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [19:0] exp_run [20];

    always #5 clk = ~clk;

    mrna_iso_seq #(
        .TW(16), .LOAD_T(2), .LYSE_T(3), .PUMP_T(1), .MIX_ROUNDS(2),
        .SEP_T(2), .WASTE_T(2), .COLLECT_T(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cells_in_ctrl(cells_in_ctrl), .cells_out_ctrl(cells_out_ctrl),
        .beads_ctrl(beads_ctrl), .lysis_in_ctrl(lysis_in_ctrl),
        .lysis_out_ctrl(lysis_out_ctrl), .sep_ctrl(sep_ctrl),
        .sieve_ctrl(sieve_ctrl), .waste_ctrl(waste_ctrl), .push_ctrl(push_ctrl),
        .collect_ctrl(collect_ctrl), .pump1(pump1), .pump2(pump2), .pump3(pump3),
        .busy(busy), .done(done), .aborted(aborted), .state(state)
    );

    // {state, cells_in, cells_out, beads, lysis_in, lysis_out, sep, sieve,
    //  waste, push, collect, pump1, pump2, pump3, busy, done, aborted}
    wire [19:0] obs = {state, cells_in_ctrl, cells_out_ctrl, beads_ctrl,
                       lysis_in_ctrl, lysis_out_ctrl, sep_ctrl, sieve_ctrl,
                       waste_ctrl, push_ctrl, collect_ctrl, pump1, pump2, pump3,
                       busy, done, aborted};

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        exp_run[0]  = {4'd1, 16'hC004};
        exp_run[1]  = {4'd1, 16'hC004};
        exp_run[2]  = {4'd2, 16'h2004};
        exp_run[3]  = {4'd2, 16'h2004};
        exp_run[4]  = {4'd3, 16'h1804};
        exp_run[5]  = {4'd3, 16'h1804};
        exp_run[6]  = {4'd3, 16'h1804};
        exp_run[7]  = {4'd4, 16'h0224};
        exp_run[8]  = {4'd4, 16'h0214};
        exp_run[9]  = {4'd4, 16'h020C};
        exp_run[10] = {4'd4, 16'h0224};
        exp_run[11] = {4'd4, 16'h0214};
        exp_run[12] = {4'd4, 16'h020C};
        exp_run[13] = {4'd5, 16'h0604};
        exp_run[14] = {4'd5, 16'h0604};
        exp_run[15] = {4'd6, 16'h0384};
        exp_run[16] = {4'd6, 16'h0384};
        exp_run[17] = {4'd7, 16'h00C4};
        exp_run[18] = {4'd7, 16'h00C4};
        exp_run[19] = {4'd8, 16'h0002};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        tick();
        tick();
        chk("reset", obs, 20'h0);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", obs, 20'h0);

        // Full run from a one-cycle start pulse; DONE lands on cycle 20.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_c1", obs, exp_run[0]);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk($sformatf("run_c%0d", i + 1), obs, exp_run[i]);
        end
        tick();
        chk("done_hold", obs, exp_run[19]);

        // Start held from DONE into BEADS: one restart, timing unchanged.
        start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("rerun_c%0d", i + 1), obs, exp_run[i]);
            if (i == 4) start = 1'b0;
        end

        // Reset in MIX: all zero, and no aborted pulse afterwards.
        rst_n = 1'b0;
        tick();
        chk("rst_in_mix", obs, 20'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_no_pulse", obs, 20'h0);

        // Abort on the second LYSE cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_run_c1", obs, exp_run[0]);
        for (int i = 1; i < 6; i++) begin
            tick();
            chk($sformatf("ab_run_c%0d", i + 1), obs, exp_run[i]);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_pulse", obs, {4'd0, 16'h0001});
        tick();
        chk("abort_pulse_end", obs, 20'h0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("after_abort_c1", obs, exp_run[0]);
        tick();
        chk("after_abort_c2", obs, exp_run[1]);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_cells", obs, {4'd0, 16'h0001});
        tick();

        // Start and abort together in IDLE: stays idle, no pulse.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", obs, 20'h0);
        tick();
        chk("start_abort_idle2", obs, 20'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
